// File: rtl/serial_to_parallel_arbiter_if.sv
// Serial request lanes plus the parallel word output of the shared deserializer.
// The slave modport is the arbiter's view; the master modport drives the lanes and observes words.
interface serial_to_parallel_arbiter_if #(
  parameter int N_CH  = 4,
  parameter int width = 8
);
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]  req_valid;
  logic [N_CH-1:0]  req_data;
  logic [N_CH-1:0]  req_ready;
  logic             parallel_valid;
  logic [width-1:0] parallel_data;
  logic [CH_W-1:0]  parallel_ch;
  logic             timeout_err;

  modport master (
    output req_valid, req_data,
    input  req_ready, parallel_valid, parallel_data, parallel_ch, timeout_err
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, parallel_valid, parallel_data, parallel_ch, timeout_err
  );
endinterface

// File: rtl/serial_to_parallel_arbiter.sv
// Round-robin shares one LSB-first deserializer among N_CH serial lanes, one word per grant.
// Optional idle-abort on the granted lane is enabled by defining S2P_ARB_TIMEOUT_EN.
module serial_to_parallel_arbiter #(
  parameter int N_CH    = 4,
  parameter int width   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  serial_to_parallel_arbiter_if.slave  bus
);
  localparam int CH_W  = $clog2(N_CH);
  localparam int CNT_W = $clog2(width + 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state;
  logic [CH_W-1:0]  grant;
  logic [CH_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [width-2:0] sreg;
  logic             pv;
  logic [width-1:0] pd;
  logic [CH_W-1:0]  pch;

  logic [CH_W-1:0]  pick;
  logic             any_req;
  int               idx;
  logic             acc;
  logic             cur_bit;
  logic [width-1:0] word_next;
  logic [N_CH-1:0]  ready;

  function automatic logic [CH_W-1:0] next_lane(input logic [CH_W-1:0] g);
    return (g == CH_W'(N_CH - 1)) ? '0 : g + 1'b1;
  endfunction

  // Walk offsets from farthest to nearest so the lane closest to rr_ptr wins.
  always_comb begin
    pick    = rr_ptr;
    any_req = 1'b0;
    idx     = 0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (bus.req_valid[CH_W'(idx)]) begin
        pick    = CH_W'(idx);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    ready = '0;
    if (state == COLLECT) ready[grant] = 1'b1;
  end

  assign cur_bit   = bus.req_data[grant];
  assign acc       = (state == COLLECT) && bus.req_valid[grant];
  assign word_next = {cur_bit, sreg};

  assign bus.req_ready      = ready;
  assign bus.parallel_valid = pv;
  assign bus.parallel_data  = pd;
  assign bus.parallel_ch    = pch;

`ifdef S2P_ARB_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              te;

  assign bus.timeout_err = te;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
      sreg     <= '0;
      idle_cnt <= '0;
      pv       <= 1'b0;
      pd       <= '0;
      pch      <= '0;
      te       <= 1'b0;
    end else begin
      pv <= 1'b0;
      te <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant    <= pick;
            state    <= COLLECT;
            cnt      <= '0;
            idle_cnt <= '0;
          end
        end
        COLLECT: begin
          if (acc) begin
            sreg     <= word_next[width-1:1];
            idle_cnt <= '0;
            if (cnt == CNT_W'(width - 1)) begin
              pv     <= 1'b1;
              pd     <= word_next;
              pch    <= grant;
              state  <= IDLE;
              cnt    <= '0;
              rr_ptr <= next_lane(grant);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
            // This gap is the TIMEOUT-th in a row: drop the partial word.
            te     <= 1'b1;
            state  <= IDLE;
            cnt    <= '0;
            rr_ptr <= next_lane(grant);
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout  = ^TIMEOUT;
  assign bus.timeout_err = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
      sreg   <= '0;
      pv     <= 1'b0;
      pd     <= '0;
      pch    <= '0;
    end else begin
      pv <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= pick;
            state <= COLLECT;
            cnt   <= '0;
          end
        end
        COLLECT: begin
          if (acc) begin
            sreg <= word_next[width-1:1];
            if (cnt == CNT_W'(width - 1)) begin
              pv     <= 1'b1;
              pd     <= word_next;
              pch    <= grant;
              state  <= IDLE;
              cnt    <= '0;
              rr_ptr <= next_lane(grant);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_serial_to_parallel_arbiter.sv
// Bench for serial_to_parallel_arbiter: directed scenarios plus random traffic,
// each cycle compared against a lane/bit-list reference model.
module tb_serial_to_parallel_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_to_parallel_arbiter_if #(.N_CH(N), .width(W)) bus ();

  serial_to_parallel_arbiter #(.N_CH(N), .width(W), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model: who owns the deserializer and which bits it has seen
  bit  m_busy;
  int  m_lane, m_rr, m_gap, m_acc;
  int  m_bits[$];
  bit  m_pv, m_te;
  int  m_pd, m_pch;
  bit  armed = 1'b0;

  int  cap_ch[$];
  int  cap_d[$];
  int  te_cnt;
  int  t2_exp[5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step(input logic [N-1:0] v, input logic [N-1:0] d, input logic r);
    bit found;
    int w;
    m_acc = -1;
    if (!r) begin
      m_busy = 0; m_lane = 0; m_rr = 0; m_gap = 0; m_bits.delete();
      m_pv = 0; m_te = 0; m_pd = 0; m_pch = 0;
      return;
    end
    m_pv = 0;
    m_te = 0;
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && v[(m_rr + k) % N]) begin
          found  = 1;
          m_busy = 1;
          m_lane = (m_rr + k) % N;
          m_gap  = 0;
          m_bits.delete();
        end
      end
    end else if (v[m_lane]) begin
      m_acc = m_lane;
      m_gap = 0;
      m_bits.push_back(int'(d[m_lane]));
      if (m_bits.size() == W) begin
        w = 0;
        foreach (m_bits[i]) w += m_bits[i] << i;
        m_pv   = 1;
        m_pd   = w;
        m_pch  = m_lane;
        m_busy = 0;
        m_rr   = (m_lane + 1) % N;
      end
    end else begin
`ifdef S2P_ARB_TIMEOUT_EN
      m_gap++;
      if (m_gap == TO) begin
        m_te   = 1;
        m_busy = 0;
        m_rr   = (m_lane + 1) % N;
      end
`endif
    end
  endfunction

  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] d, input logic r);
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    if (armed) begin
      exp_rdy = '0;
      if (m_busy) exp_rdy[m_lane] = 1'b1;
      chk("ready",   bus.req_ready, exp_rdy);
      chk("onehot0", $onehot0(bus.req_ready), 1);
      chk("pvalid",  bus.parallel_valid, m_pv);
      chk("pdata",   bus.parallel_data, m_pd);
      chk("pch",     bus.parallel_ch, m_pch);
      chk("terr",    bus.timeout_err, m_te);
      if (bus.parallel_valid) begin
        cap_ch.push_back(int'(bus.parallel_ch));
        cap_d.push_back(int'(bus.parallel_data));
      end
      if (bus.timeout_err) te_cnt++;
    end
    bus.req_valid = v;
    bus.req_data  = d;
    rst           = r;
    model_step(v, d, r);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle('0, N'($urandom), 1'b1);
  endtask

  task automatic do_reset();
    cycle(N'($urandom), N'($urandom), 1'b0);
  endtask

  task automatic clear_caps();
    cap_ch.delete();
    cap_d.delete();
    te_cnt = 0;
  endtask

  task automatic send_bits(input int lane, input logic [W-1:0] word, input int nbits, input bit gappy);
    int n  = 0;
    int it = 0;
    logic [N-1:0] v, d;
    while (n < nbits && it < 200) begin
      v       = '0;
      d       = N'($urandom);
      d[lane] = word[n];
      if (!(gappy && (it % 2 == 1))) v[lane] = 1'b1;
      cycle(v, d, 1'b1);
      if (m_acc == lane) n++;
      it++;
    end
    chk("send_done", n, nbits);
  endtask

  initial begin
    logic [W-1:0] w;
    bus.req_valid = '0;
    bus.req_data  = '0;
    cycle('0, '0, 1'b0);
    armed = 1'b1;
    cycle('0, '0, 1'b0);
    idle(2);

    // lane 2 alone, LSB-first 1,0,1,1,0,0,1,0
    clear_caps();
    send_bits(2, 8'h4D, 8, 1'b0);
    idle(2);
    chk("t1_count", cap_ch.size(), 1);
    if (cap_ch.size() >= 1) begin
      chk("t1_data", cap_d[0], 8'h4D);
      chk("t1_ch", cap_ch[0], 2);
    end

    // every lane always valid: round-robin order from lane 0
    do_reset();
    clear_caps();
    repeat (48) cycle('1, N'($urandom), 1'b1);
    for (int i = 0; i < 5; i++)
      chk("t2_order", (i < cap_ch.size()) ? cap_ch[i] : -1, t2_exp[i]);

    // lane 1 valid every other cycle
    do_reset();
    clear_caps();
    w = W'($urandom);
    send_bits(1, w, 8, 1'b1);
    idle(2);
    chk("t3_count", cap_ch.size(), 1);
    if (cap_ch.size() >= 1) begin
      chk("t3_data", cap_d[0], w);
      chk("t3_ch", cap_ch[0], 1);
    end

    // reset in the middle of a lane-0 word, then a clean word
    do_reset();
    clear_caps();
    send_bits(0, W'($urandom), 5, 1'b0);
    cycle('0, '0, 1'b0);
    @(negedge clk);
    chk("t4_ready", bus.req_ready, 0);
    chk("t4_pvalid", bus.parallel_valid, 0);
    chk("t4_pdata", bus.parallel_data, 0);
    chk("t4_pch", bus.parallel_ch, 0);
    send_bits(0, 8'hA5, 8, 1'b0);
    idle(2);
    chk("t4_count", cap_ch.size(), 1);
    if (cap_ch.size() >= 1) begin
      chk("t4_data", cap_d[0], 8'hA5);
      chk("t4_ch", cap_ch[0], 0);
    end

    // lane 3 stalls after 3 bits
    do_reset();
    clear_caps();
    send_bits(3, W'($urandom), 3, 1'b0);
    idle(18);
    chk("t5_nopulse", cap_ch.size(), 0);
`ifdef S2P_ARB_TIMEOUT_EN
    chk("t5_terr", te_cnt, 1);
`else
    chk("t5_terr", te_cnt, 0);
`endif
    repeat (14) cycle(4'b1001, N'($urandom), 1'b1);
    chk("t5_after", cap_ch.size() >= 1, 1);
    if (cap_ch.size() >= 1) begin
`ifdef S2P_ARB_TIMEOUT_EN
      chk("t5_next_ch", cap_ch[0], 0);
`else
      chk("t5_next_ch", cap_ch[0], 3);
`endif
    end

    // rr pointer at 3, then lanes 0 and 3 compete: 3 first, then wrap to 0
    do_reset();
    send_bits(2, W'($urandom), 8, 1'b0);
    idle(1);
    clear_caps();
    repeat (22) cycle(4'b1001, N'($urandom), 1'b1);
    chk("t6_count", cap_ch.size(), 2);
    if (cap_ch.size() >= 2) begin
      chk("t6_first", cap_ch[0], 3);
      chk("t6_second", cap_ch[1], 0);
    end

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++)
      cycle(N'($urandom), N'($urandom), ($urandom_range(0, 99) != 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
